pipe_hazard_unit: RTL and testbench
===================================

// Module: pipe_hazard_unit
// PURPOSE
// Parametrised hazard-detection and forwarding controller for the in-order pipeline.
// Sits beside the ID stage and keeps a shift-register scoreboard of in-flight destination registers for stages 1..DEPTH (1=EX, 2=MEM, 3=WB at default).
// Each cycle it compares the ID instruction's source registers against the scoreboard. It then drives stall/bubble, forwarding selects and branch-flush squashing.
// PARAMETERS
// REG_AW    4  register-address width (2**REG_AW architectural regs; R0 hardwired zero)
// DEPTH     3  tracked stages after ID (EX..WB), >=2
// LOAD_LAT  1  extra cycles after EX before load data can be forwarded (>=0, <DEPTH)
// FW        $clog2(DEPTH+1)  forward-select width (derived, localparam)
// PORTS
// clk          in   1       clock, rising edge
// rst_n        in   1       reset, asynchronous, active-low
// id_valid     in   1       ID holds a real instruction
// id_src0      in   REG_AW  first source reg;  id_src0_en in 1: source 0 is read
// id_src1      in   REG_AW  second source reg; id_src1_en in 1: source 1 is read
// id_dst       in   REG_AW  destination reg;   id_dst_en  in 1: instruction writes rf
// id_is_load   in   1       ID instruction is a memory load
// ex_flush     in   1       taken branch resolved in EX; squash ID/IF instructions
// stall        out  1       load-use / RAW stall this cycle
// pc_write     out  1       ~stall; PC may advance
// if_id_write  out  1       ~stall; IF/ID latch may load
// id_ex_bubble out  1       stall | ex_flush; ID/EX control zeroed
// fwd0_sel     out  FW      source-0 operand select: 0=rf, k=result bus of stage k
// fwd1_sel     out  FW      source-1 operand select, same encoding
// stall_cycles out  16      saturating count of stall cycles
// BEHAVIOUR
// - Scoreboard entry k: {vld, dst, is_load}. All vld=0 and stall_cycles=0 on reset, so all outputs reset to 0 except pc_write=if_id_write=1.
// - Each clk: entry k+1 <= entry k (k=1..DEPTH-1); entry DEPTH retires.
// - Entry 1 loads {id_valid&id_dst_en&(id_dst!=0), id_dst, id_is_load} unless id_ex_bubble, in which case vld=0.
// - Match(s,k) = src_en & vld_k & (dst_k==src) & (src!=0). R0 never hazards.
// - With multiple matches, the youngest (lowest k) wins.
// - Load-use: the youngest match with is_load and k<=LOAD_LAT raises stall while id_valid.
// - Other matches forward: fwd_sel = k of the youngest match. No match -> sel 0.
// - During stall, fwd sels are don't-care but driven to 0.
// - ex_flush has priority: stall=0 and fwd sels=0 that cycle; the ID instruction enters as a bubble.
// - A stall with ex_flush never counts. Older entries (k>=1) are never cleared by flush.
// - stall, fwd sels and id_ex_bubble are combinational from scoreboard + ID inputs, zero latency. Scoreboard updates on the next edge.
// - stall_cycles increments on each stall=1 edge and saturates at 16'hFFFF, no wrap.
// - A reset asserted mid-stall clears the scoreboard immediately (async). Stall drops in the same cycle.
// - Back-to-back stalls hold the ID inputs constant; the scoreboard drains one stage per cycle until the load reaches k=LOAD_LAT+1.
// CONFIGURATION
// PIPE_FWD_EN defined: forwarding as above.
// PIPE_FWD_EN undefined: fwd0_sel=fwd1_sel=0 always. Any match in stages 1..DEPTH stalls (loads and ALU ops alike) until the writer retires.
// TESTING
// 1. ADD R1 then ADD R2,R1,R3 back-to-back (fwd on) -> fwd0_sel=1, stall=0; next instr using R1 -> fwd sel=2.
// 2. LW R3 then ADD R4,R3,R5, LOAD_LAT=1 -> stall=1 one cycle, pc_write=0, stall_cycles=1; following cycle fwd0_sel=2.
// 3. ADD R0 then ADD R2,R0,R0 -> no stall, both sels 0.
// 4. LW R3 + dependent in ID with ex_flush=1 same cycle -> stall=0, id_ex_bubble=1, entry 1 vld=0, stall_cycles unchanged.
// 5. PIPE_FWD_EN undefined: ADD R1; ADD R2,R1 -> stall for exactly DEPTH=3 cycles, sels 0, stall_cycles=3.
// 6. rst_n low during a stall -> stall=0 immediately, stall_cycles=0. Force 16'hFFFF then stall again -> remains 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: ID-side RAW hazard detection, operand forwarding and flush squashing over an in-flight dst scoreboard.
// Define PIPE_FWD_EN for forwarding; without it every RAW match stalls until the writer retires.
module pipe_hazard_unit #(
   parameter int  REG_AW   = 4,
   parameter int  DEPTH    = 3,
   parameter int  LOAD_LAT = 1,
   localparam int FW       = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_src0_i,
   input  logic              id_src0_en_i,
   input  logic [REG_AW-1:0] id_src1_i,
   input  logic              id_src1_en_i,
   input  logic [REG_AW-1:0] id_dst_i,
   input  logic              id_dst_en_i,
   input  logic              id_is_load_i,
   input  logic              ex_flush_i,
   output logic              stall_o,
   output logic              pc_write_o,
   output logic              if_id_write_o,
   output logic              id_ex_bubble_o,
   output logic [FW-1:0]     fwd0_sel_o,
   output logic [FW-1:0]     fwd1_sel_o,
   output logic [15:0]       stall_cycles_o
);
   logic [DEPTH:1]    vld_q, vld_d, ld_q, ld_d, m0, m1;
   logic [REG_AW-1:0] dst_q [1:DEPTH];
   logic [REG_AW-1:0] dst_d [1:DEPTH];
   logic [15:0]       cnt_q, cnt_d;

   for (genvar k = 1; k <= DEPTH; k++) begin : g_match
      assign m0[k] = id_src0_en_i && vld_q[k] && dst_q[k] == id_src0_i && id_src0_i != '0;
      assign m1[k] = id_src1_en_i && vld_q[k] && dst_q[k] == id_src1_i && id_src1_i != '0;
   end

`ifdef PIPE_FWD_EN
   logic [FW-1:0] sel0, sel1;
   logic          lu0, lu1;
   // Scan oldest to youngest so the youngest match overwrites.
   always_comb begin
      sel0 = '0;
      sel1 = '0;
      lu0  = 1'b0;
      lu1  = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (m0[k]) begin
            sel0 = FW'(k);
            lu0  = ld_q[k] && k <= LOAD_LAT;
         end
         if (m1[k]) begin
            sel1 = FW'(k);
            lu1  = ld_q[k] && k <= LOAD_LAT;
         end
      end
   end
   assign stall_o    = id_valid_i && !ex_flush_i && (lu0 || lu1);
   assign fwd0_sel_o = (stall_o || ex_flush_i) ? '0 : sel0;
   assign fwd1_sel_o = (stall_o || ex_flush_i) ? '0 : sel1;
`else
   logic unused_ld;
   assign unused_ld  = ^ld_q;
   assign stall_o    = id_valid_i && !ex_flush_i && (|m0 || |m1);
   assign fwd0_sel_o = '0;
   assign fwd1_sel_o = '0;
`endif

   assign pc_write_o     = !stall_o;
   assign if_id_write_o  = !stall_o;
   assign id_ex_bubble_o = stall_o || ex_flush_i;
   assign stall_cycles_o = cnt_q;

   always_comb begin
      vld_d    = {vld_q[DEPTH-1:1], id_valid_i && id_dst_en_i && id_dst_i != '0 && !id_ex_bubble_o};
      ld_d     = {ld_q[DEPTH-1:1], id_is_load_i};
      dst_d[1] = id_dst_i;
      for (int k = 2; k <= DEPTH; k++) dst_d[k] = dst_q[k-1];
      cnt_d    = (stall_o && cnt_q != '1) ? cnt_q + 16'd1 : cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         cnt_q <= '0;
      end else begin
         vld_q <= vld_d;
         cnt_q <= cnt_d;
      end
   end

   // Payload needs no reset: it is only looked at behind vld_q.
   always_ff @(posedge clk) begin
      ld_q  <= ld_d;
      dst_q <= dst_d;
   end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed scenarios plus randomized traffic against a queue-based scoreboard model.
module tb_pipe_hazard_unit;
   localparam int REG_AW   = 4;
   localparam int DEPTH    = 3;
   localparam int LOAD_LAT = 1;
   localparam int FW       = $clog2(DEPTH + 1);
`ifdef PIPE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b1;
   logic id_valid, id_src0_en, id_src1_en, id_dst_en, id_is_load, ex_flush;
   logic [REG_AW-1:0] id_src0, id_src1, id_dst;
   logic stall, pc_write, if_id_write, bubble;
   logic [FW-1:0] fwd0, fwd1;
   logic [15:0] cnt;
   logic [3+2*FW:0] outs;
   int n_tests = 0, n_fail = 0;

   typedef struct packed {logic vld; logic [REG_AW-1:0] dst; logic ld;} ent_t;
   ent_t sbq[$];
   logic [15:0] m_cnt;

   always #5 clk = ~clk;
   assign outs = {stall, pc_write, if_id_write, bubble, fwd0, fwd1};

   pipe_hazard_unit #(.REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid),
      .id_src0_i(id_src0), .id_src0_en_i(id_src0_en), .id_src1_i(id_src1), .id_src1_en_i(id_src1_en),
      .id_dst_i(id_dst), .id_dst_en_i(id_dst_en), .id_is_load_i(id_is_load), .ex_flush_i(ex_flush),
      .stall_o(stall), .pc_write_o(pc_write), .if_id_write_o(if_id_write), .id_ex_bubble_o(bubble),
      .fwd0_sel_o(fwd0), .fwd1_sel_o(fwd1), .stall_cycles_o(cnt));

   // Reference model: index 0 of the queue is the instruction that left ID most recently.
   function automatic int youngest(input logic en, input logic [REG_AW-1:0] src);
      if (!en || src == '0) return 0;
      foreach (sbq[i]) if (sbq[i].vld && sbq[i].dst == src) return i + 1;
      return 0;
   endfunction

   function automatic logic exp_stall();
      int  k0 = youngest(id_src0_en, id_src0);
      int  k1 = youngest(id_src1_en, id_src1);
      logic h0 = k0 != 0 && (!FWD || (sbq[k0-1].ld && k0 <= LOAD_LAT));
      logic h1 = k1 != 0 && (!FWD || (sbq[k1-1].ld && k1 <= LOAD_LAT));
      return id_valid && !ex_flush && (h0 || h1);
   endfunction

   function automatic logic [FW-1:0] exp_sel(input bit s);
      int k = s ? youngest(id_src1_en, id_src1) : youngest(id_src0_en, id_src0);
      return (FWD && !ex_flush && !exp_stall()) ? FW'(k) : '0;
   endfunction

   function automatic logic [3+2*FW:0] pack(input logic st, input logic bub, input logic [FW-1:0] s0, input logic [FW-1:0] s1);
      return {st, !st, !st, bub, s0, s1};
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      logic st;
      if (!rst_n) begin
         sbq = {};
         repeat (DEPTH) sbq.push_back('0);
         m_cnt = '0;
      end else begin
         st = exp_stall();
         sbq.push_front({id_valid && id_dst_en && id_dst != '0 && !st && !ex_flush, id_dst, id_is_load});
         void'(sbq.pop_back());
         if (st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
   end

   task automatic put(input logic v, input logic [REG_AW-1:0] s0, input logic e0, input logic [REG_AW-1:0] s1,
                      input logic e1, input logic [REG_AW-1:0] d, input logic de, input logic ld, input logic fl);
      @(negedge clk);
      id_valid = v; id_src0 = s0; id_src0_en = e0; id_src1 = s1; id_src1_en = e1;
      id_dst = d; id_dst_en = de; id_is_load = ld; ex_flush = fl;
      #1;
   endtask

   task automatic alu(input logic [REG_AW-1:0] d, input logic [REG_AW-1:0] s0, input logic [REG_AW-1:0] s1);
      put(1'b1, s0, 1'b1, s1, 1'b1, d, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic lw(input logic [REG_AW-1:0] d, input logic [REG_AW-1:0] s0);
      put(1'b1, s0, 1'b1, 4'd0, 1'b0, d, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) put(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      idle(1);
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (outs !== pack(1'b0, 1'b0, '0, '0)) begin
         n_fail++; $display("FAIL reset_outs got %h want %h", outs, pack(1'b0, 1'b0, '0, '0));
      end
      n_tests++;
      if (cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %h want 0000", cnt); end
      @(negedge clk) rst_n = 1'b1;
   endtask

`ifdef PIPE_FWD_EN
   task automatic test_fwd_chain();
      idle(DEPTH);
      alu(4'd1, 4'd2, 4'd3);
      n_tests++;
      if (outs !== pack(1'b0, 1'b0, '0, '0)) begin n_fail++; $display("FAIL chain_first got %h", outs); end
      alu(4'd2, 4'd1, 4'd3);
      n_tests++;
      if (outs !== pack(1'b0, 1'b0, FW'(1), '0)) begin
         n_fail++; $display("FAIL chain_fwd1 got %h want %h", outs, pack(1'b0, 1'b0, FW'(1), '0));
      end
      alu(4'd5, 4'd4, 4'd1);
      n_tests++;
      if (outs !== pack(1'b0, 1'b0, '0, FW'(2))) begin
         n_fail++; $display("FAIL chain_fwd2 got %h want %h", outs, pack(1'b0, 1'b0, '0, FW'(2)));
      end
   endtask

   task automatic test_load_use();
      logic [15:0] c;
      idle(DEPTH);
      lw(4'd3, 4'd1);
      c = cnt;
      alu(4'd4, 4'd3, 4'd5);
      n_tests++;
      if (outs !== pack(1'b1, 1'b1, '0, '0)) begin
         n_fail++; $display("FAIL lu_stall got %h want %h", outs, pack(1'b1, 1'b1, '0, '0));
      end
      alu(4'd4, 4'd3, 4'd5);
      n_tests++;
      if (outs !== pack(1'b0, 1'b0, FW'(2), '0)) begin
         n_fail++; $display("FAIL lu_fwd got %h want %h", outs, pack(1'b0, 1'b0, FW'(2), '0));
      end
      n_tests++;
      if (cnt !== c + 16'd1) begin n_fail++; $display("FAIL lu_cnt got %h want %h", cnt, c + 16'd1); end
   endtask
`else
   task automatic test_nofwd_stall();
      logic [15:0] c;
      idle(DEPTH);
      alu(4'd1, 4'd2, 4'd3);
      c = cnt;
      for (int i = 0; i < 4; i++) begin
         alu(4'd2, 4'd1, 4'd3);
         n_tests++;
         if (outs !== pack(i < 3, i < 3, '0, '0)) begin
            n_fail++; $display("FAIL nofwd_stall[%0d] got %h want %h", i, outs, pack(i < 3, i < 3, '0, '0));
         end
      end
      n_tests++;
      if (cnt !== c + 16'd3) begin n_fail++; $display("FAIL nofwd_cnt got %h want %h", cnt, c + 16'd3); end
   endtask
`endif

   task automatic test_r0();
      idle(DEPTH);
      alu(4'd0, 4'd2, 4'd3);
      alu(4'd2, 4'd0, 4'd0);
      n_tests++;
      if (outs !== pack(1'b0, 1'b0, '0, '0)) begin n_fail++; $display("FAIL r0 got %h", outs); end
   endtask

   task automatic test_flush();
      logic [15:0] c;
      idle(DEPTH);
      lw(4'd3, 4'd1);
      c = cnt;
      put(1'b1, 4'd3, 1'b1, 4'd5, 1'b1, 4'd4, 1'b1, 1'b0, 1'b1);
      n_tests++;
      if (outs !== pack(1'b0, 1'b1, '0, '0)) begin
         n_fail++; $display("FAIL flush_outs got %h want %h", outs, pack(1'b0, 1'b1, '0, '0));
      end
      alu(4'd6, 4'd4, 4'd3);
      n_tests++;
      if (outs !== pack(!FWD, !FWD, '0, FWD ? FW'(2) : FW'(0))) begin
         n_fail++; $display("FAIL flush_after got %h want %h", outs, pack(!FWD, !FWD, '0, FWD ? FW'(2) : FW'(0)));
      end
      n_tests++;
      if (cnt !== c) begin n_fail++; $display("FAIL flush_cnt got %h want %h", cnt, c); end
   endtask

   task automatic test_reset_mid_stall();
      idle(DEPTH);
      lw(4'd3, 4'd1);
      alu(4'd4, 4'd3, 4'd5);
      n_tests++;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL mid_pre got %b want 1", stall); end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({stall, pc_write, cnt} !== {1'b0, 1'b1, 16'd0}) begin
         n_fail++; $display("FAIL mid_rst got stall=%b pc=%b cnt=%h want 0 1 0000", stall, pc_write, cnt);
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_saturate();
      idle(DEPTH);
      force dut.cnt_q = 16'hFFFE;
      #1 release dut.cnt_q;
      for (int r = 0; r < 2; r++) begin
         lw(4'd3, 4'd1);
         repeat (DEPTH) alu(4'd4, 4'd3, 4'd5);
         n_tests++;
         if (cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat[%0d] got %h want ffff", r, cnt); end
      end
      idle(1);
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [3+2*FW:0] e;
      for (int i = 0; i < 400; i++) begin
         put($urandom_range(0, 7) != 0, 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
         e = pack(exp_stall(), exp_stall() || ex_flush, exp_sel(1'b0), exp_sel(1'b1));
         n_tests++;
         if (outs !== e) begin n_fail++; $display("FAIL rand_outs[%0d] got %h want %h", i, outs, e); end
         n_tests++;
         if (cnt !== m_cnt) begin n_fail++; $display("FAIL rand_cnt[%0d] got %h want %h", i, cnt, m_cnt); end
      end
   endtask

   initial begin
      test_reset();
`ifdef PIPE_FWD_EN
      test_fwd_chain();
      test_load_use();
`else
      test_nofwd_stall();
`endif
      test_r0();
      test_flush();
      test_reset_mid_stall();
      test_saturate();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
